// File: rtl/calc_keypad_pkg.sv
// Shared definitions for the calculator keypad front end: operator codes,
// scanner state encoding and the 4x4 keymap.
package calc_keypad_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_EQ  = 3'd4;

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] EMIT     = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  typedef enum logic [1:0] {
    KEY_NONE = 2'd0,
    KEY_NUM  = 2'd1,
    KEY_OP   = 2'd2,
    KEY_CLR  = 2'd3
  } key_class_t;

  typedef struct packed {
    key_class_t cls;
    logic [3:0] val;
  } key_info_t;

  function automatic key_info_t keymap(input logic [1:0] r, input logic [1:0] c);
    key_info_t k;
    k.cls = KEY_NUM;
    k.val = 4'd0;
    case ({r, c})
      4'h0: k.val = 4'd1;
      4'h1: k.val = 4'd2;
      4'h2: k.val = 4'd3;
      4'h3: begin k.cls = KEY_OP; k.val = {1'b0, OP_ADD}; end
      4'h4: k.val = 4'd4;
      4'h5: k.val = 4'd5;
      4'h6: k.val = 4'd6;
      4'h7: begin k.cls = KEY_OP; k.val = {1'b0, OP_SUB}; end
      4'h8: k.val = 4'd7;
      4'h9: k.val = 4'd8;
      4'hA: k.val = 4'd9;
      4'hB: begin k.cls = KEY_OP; k.val = {1'b0, OP_MUL}; end
      4'hC: k.cls = KEY_CLR;
      4'hD: k.val = 4'd0;
      4'hE: begin k.cls = KEY_OP; k.val = {1'b0, OP_EQ}; end
      4'hF: begin k.cls = KEY_OP; k.val = {1'b0, OP_DIV}; end
      default: k.cls = KEY_NONE;
    endcase
    return k;
  endfunction

  // True when exactly one active-low row is asserted.
  function automatic logic row_single(input logic [3:0] rs);
    case (rs)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] row_enc(input logic [3:0] rs);
    case (rs)
      4'b1110: return 2'd0;
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchroniser for the asynchronous keypad rows; resets to the
// idle (all released) level.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Metastability filter chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= {WIDTH{1'b1}};
      q    <= {WIDTH{1'b1}};
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, row debounce, key classification
// and one registered pulse per physical press.
module keypad_scanner
  import calc_keypad_pkg::*;
#(
  parameter int SCAN_DIV   = 4,
  parameter int DEBOUNCE_N = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       rec_num,
  output logic       rec_op,
  output logic       clr,
  output logic [3:0] key_val,
  output logic [2:0] op_code
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_N + 1);

  logic [3:0]       rs;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [1:0]       state, state_nx;
  logic [1:0]       col_idx, col_idx_nx;
  logic [1:0]       row_idx, row_idx_nx;
  logic [CNT_W-1:0] db_cnt, db_nx;
  logic [CNT_W-1:0] rel_cnt, rel_nx;
  logic             single;
  logic             entering_emit;
  key_info_t        info;

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row),
    .q     (rs)
  );

  assign tick   = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign single = row_single(rs);

  // Scan/debounce/release sequencing; the column only moves when leaving a key.
  always_comb begin
    state_nx   = state;
    col_idx_nx = col_idx;
    row_idx_nx = row_idx;
    db_nx      = db_cnt;
    rel_nx     = rel_cnt;
    case (state)
      SCAN: begin
        if (tick && single) begin
          row_idx_nx = row_enc(rs);
          db_nx      = CNT_W'(1);
          state_nx   = DEBOUNCE;
        end else if (tick) begin
          col_idx_nx = col_idx + 2'd1;
        end else begin
          state_nx = SCAN;
        end
      end
      DEBOUNCE: begin
        if (tick && single && (row_enc(rs) == row_idx)) begin
          db_nx = db_cnt + CNT_W'(1);
          if (db_nx == CNT_W'(DEBOUNCE_N)) begin
            state_nx = EMIT;
          end else begin
            state_nx = DEBOUNCE;
          end
        end else if (tick) begin
          state_nx   = SCAN;
          col_idx_nx = col_idx + 2'd1;
        end else begin
          state_nx = DEBOUNCE;
        end
      end
      EMIT: begin
        state_nx = RELEASE;
        rel_nx   = CNT_W'(0);
      end
      RELEASE: begin
        if (tick && (rs == 4'b1111)) begin
          rel_nx = rel_cnt + CNT_W'(1);
          if (rel_nx == CNT_W'(DEBOUNCE_N)) begin
            state_nx   = SCAN;
            col_idx_nx = col_idx + 2'd1;
          end else begin
            state_nx = RELEASE;
          end
        end else if (tick) begin
          rel_nx = CNT_W'(0);
        end else begin
          state_nx = RELEASE;
        end
      end
      default: begin
        state_nx = SCAN;
      end
    endcase
  end

  assign entering_emit = (state_nx == EMIT) && (state != EMIT);
  assign info          = keymap(row_idx_nx, col_idx);

  // State, column drive and output pulses, all registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      state   <= SCAN;
      col_idx <= 2'd0;
      row_idx <= 2'd0;
      db_cnt  <= '0;
      rel_cnt <= '0;
      col     <= 4'b1110;
      rec_num <= 1'b0;
      rec_op  <= 1'b0;
      clr     <= 1'b0;
      key_val <= 4'd0;
      op_code <= 3'd0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      state   <= state_nx;
      col_idx <= col_idx_nx;
      row_idx <= row_idx_nx;
      db_cnt  <= db_nx;
      rel_cnt <= rel_nx;
      col     <= ~(4'b0001 << col_idx_nx);
      rec_num <= entering_emit && (info.cls == KEY_NUM);
      rec_op  <= entering_emit && (info.cls == KEY_OP);
      clr     <= entering_emit && (info.cls == KEY_CLR);
      if (entering_emit && (info.cls == KEY_NUM)) begin
        key_val <= info.val;
      end
      if (entering_emit && (info.cls == KEY_OP)) begin
        op_code <= info.val[2:0];
      end
    end
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Front end of the calculator; sits directly upstream of the calculator control FSM.
- Scans a 4x4 active-low matrix keypad, synchronises and debounces the rows, and classifies each key.
- Emits exactly one single-cycle pulse per physical press: rec_num carries a digit, rec_op carries an operator or '=', clr carries clear.
- rec_num and rec_op connect straight to the control FSM's rec_num/rec_op inputs; key_val and op_code feed the operand datapath.

Parameters:
SCAN_DIV, 4, clock cycles per column dwell; legal minimum 4.
DEBOUNCE_N, 3, consecutive stable samples needed for press and for release; legal minimum 2.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
row  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
col  output  4  keypad column drive, active-low one-hot.
rec_num  output  1  one-cycle pulse: digit key accepted.
rec_op  output  1  one-cycle pulse: operator or '=' accepted.
clr  output  1  one-cycle pulse: '*' (clear) accepted.
key_val  output  4  digit 0-9, valid while rec_num=1, otherwise holds its last value.
op_code  output  3  0=add, 1=sub, 2=mul, 3=div, 4=equals; valid while rec_op=1, otherwise holds its last value.

Behaviour:
- Reset (asynchronous, active-low) forces:
  - state=SCAN, col_idx=0, col=4'b1110, divider=0, counters=0.
  - rec_num, rec_op, clr = 0; key_val = 0; op_code = 0.
- row passes through a 2-FF synchroniser; all decisions use the synchronised value rs.
- Divider counts 0..SCAN_DIV-1 and wraps. A tick is the cycle where divider = SCAN_DIV-1. Every FSM decision happens only on a tick, except EMIT.
- col = ~(1<<col_idx); col changes only when col_idx changes.
- "Single" means exactly one bit of rs is low. Two or more low bits in one column count as no key and are ignored.
- SCAN, on tick:
  - rs single: latch row_idx, db_cnt=1, go DEBOUNCE; col_idx unchanged.
  - otherwise: col_idx advances, wrapping 3->0.
- DEBOUNCE, on tick, column frozen:
  - rs single and same row_idx: db_cnt++. When db_cnt reaches DEBOUNCE_N, go EMIT.
  - otherwise: go SCAN and advance col_idx.
- EMIT, lasts exactly one cycle:
  - Exactly one of rec_num/rec_op/clr is 1 in this cycle; key_val or op_code updates in the same cycle.
  - Then go RELEASE with rel_cnt=0.
- RELEASE, on tick, column frozen:
  - rs=4'b1111: rel_cnt++.
  - any row low: rel_cnt=0.
  - When rel_cnt reaches DEBOUNCE_N: go SCAN and advance col_idx.
  - A held key therefore never re-triggers.
- Keymap, row r, col c:
  - r0: 1, 2, 3, A(add)
  - r1: 4, 5, 6, B(sub)
  - r2: 7, 8, 9, C(mul)
  - r3: *(clr), 0, #(equals), D(div)
- Pulse timing: pulses are registered (Moore on state EMIT). Latency from the detecting SCAN tick to the pulse cycle is SCAN_DIV*(DEBOUNCE_N-1)+1 clocks; for the defaults this is 9.
- Boundary conditions:
  - A second key pressed in another column during DEBOUNCE or RELEASE is not seen: the column is frozen.
  - A second key in the same column during DEBOUNCE makes rs non-single, so it aborts to SCAN.
  - Reset mid-operation discards any pending key; no pulse is produced.
  - Pulses are mutually exclusive; at most one pulse per EMIT cycle.

Decomposition:
- Shared package calc_keypad_pkg holds:
  - op_code constants OP_ADD..OP_EQ;
  - the state encoding SCAN/DEBOUNCE/EMIT/RELEASE;
  - the 16-entry keymap function (row, col) -> class, value.
- Sub-module sync_2ff (width parameter, asynchronous active-low reset to all-ones) for the row synchroniser.

Test Plan:
- Reset, then idle with row=4'b1111 for 40 clocks -> col cycles 1110,1101,1011,0111, changing every 4 clocks; no pulses.
- Hold '5' (row1 low while col=1101) for 200 clocks -> exactly one rec_num pulse with key_val=5, 9 clocks after the first detecting tick; col frozen at 1101 until release completes.
- Press 'C' for only 1 tick, then release -> no pulse; scanning resumes at the next column.
- Sequence '7','A','3','#','*', each held 50 clocks with 50 clocks released between -> pulses in order:
  - rec_num 7
  - rec_op 0
  - rec_num 3
  - rec_op 4
  - clr
- After a '2' pulse, bounce the release (high, low, high, high, high across ticks) -> rel_cnt restarts; return to SCAN only after 3 clean high ticks; no second pulse.
- Assert rst_n=0 mid-DEBOUNCE of '9' -> outputs zero, col=1110, no pulse.
- Press rows 0 and 2 together in col0 -> no pulse.
